// File: rtl/ddr_color_pkg.sv
// Shared colour-theme types, palette table and sequencer state encoding.
// Colours are RGB332; each theme defines a player, note and menu colour.
package ddr_color_pkg;

  typedef logic [7:0] rgb332_t;
  typedef logic [1:0] theme_t;

  typedef struct packed {
    rgb332_t player;
    rgb332_t note;
    rgb332_t menu;
  } palette_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  localparam palette_t THEME0 = '{player: 8'hE0, note: 8'h03, menu: 8'hFF};
  localparam palette_t THEME1 = '{player: 8'h55, note: 8'h7A, menu: 8'hAA};
  localparam palette_t THEME2 = '{player: 8'h1F, note: 8'hE3, menu: 8'hE3};
  localparam palette_t THEME3 = '{player: 8'h1F, note: 8'hE3, menu: 8'h1F};

  function automatic palette_t palette(input theme_t t);
    case (t)
      2'd0:    palette = THEME0;
      2'd1:    palette = THEME1;
      2'd2:    palette = THEME2;
      default: palette = THEME3;
    endcase
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector with a programmable reset value for the stored level,
// so a level already high at reset release can be made not to fire.
module rise_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!rst) prev <= RST_VAL;
    else      prev <= sig;
  end

  assign rise = sig & ~prev;

endmodule

// File: rtl/theme_sequencer.sv
// Colour-theme sequencer: admits change requests in menu mode, commits the
// next palette on a vsync_start edge, then holds off further changes.
module theme_sequencer
  import ddr_color_pkg::*;
#(
  parameter int NUM_THEMES     = 4,
  parameter int LOCKOUT_CYCLES = 5_000_000
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    btn_chg,
  input  logic    mode,
  input  logic    vsync_start,
  output rgb332_t vga_note,
  output rgb332_t vga_player,
  output rgb332_t vga_menu,
  output theme_t  theme,
  output logic    pending,
  output logic    locked
);

  localparam int CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam theme_t LAST_THEME = theme_t'(NUM_THEMES - 1);

  state_t           state, state_n;
  theme_t           theme_n, next_theme, next_theme_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             btn_rise;
  logic             commit;
  palette_t         pal_next;

  // btn_prev resets high so a button held through reset does not fire
  rise_detect #(.RST_VAL(1'b1)) u_btn_rise (
    .clk  (clk),
    .rst  (rst),
    .sig  (btn_chg),
    .rise (btn_rise)
  );

  assign pal_next = palette(next_theme);
  assign pending  = (state == PENDING);
  assign locked   = (state == LOCKOUT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      theme      <= '0;
      next_theme <= '0;
      cnt        <= '0;
      vga_player <= THEME0.player;
      vga_note   <= THEME0.note;
      vga_menu   <= THEME0.menu;
    end else begin
      state      <= state_n;
      theme      <= theme_n;
      next_theme <= next_theme_n;
      cnt        <= cnt_n;
      if (commit) begin
        vga_player <= pal_next.player;
        vga_note   <= pal_next.note;
        vga_menu   <= pal_next.menu;
      end
    end
  end

  always_comb begin
    state_n      = state;
    theme_n      = theme;
    next_theme_n = next_theme;
    cnt_n        = cnt;
    commit       = 1'b0;
    case (state)
      IDLE: begin
        if (btn_rise && mode) begin
          next_theme_n = (theme == LAST_THEME) ? '0 : theme + 2'd1;
          state_n      = PENDING;
        end
      end
      PENDING: begin
        // leaving menu mode cancels; vsync in the accept cycle is never seen here
        if (!mode) begin
          state_n = IDLE;
        end else if (vsync_start) begin
          commit  = 1'b1;
          theme_n = next_theme;
          cnt_n   = CNT_LOAD;
          state_n = LOCKOUT;
        end
      end
      LOCKOUT: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_theme_sequencer.sv
// Directed self-checking bench for theme_sequencer (LOCKOUT_CYCLES=8, 4 themes).
module tb_theme_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_chg = 1'b1;
  logic       mode = 1'b0;
  logic       vsync_start = 1'b0;
  logic [7:0] vga_note, vga_player, vga_menu;
  logic [1:0] theme;
  logic       pending, locked;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_pl [4] = '{8'hE0, 8'h55, 8'h1F, 8'h1F};
  logic [7:0] exp_nt [4] = '{8'h03, 8'h7A, 8'hE3, 8'hE3};
  logic [7:0] exp_mn [4] = '{8'hFF, 8'hAA, 8'hE3, 8'h1F};

  theme_sequencer #(.NUM_THEMES(4), .LOCKOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_chg     (btn_chg),
    .mode        (mode),
    .vsync_start (vsync_start),
    .vga_note    (vga_note),
    .vga_player  (vga_player),
    .vga_menu    (vga_menu),
    .theme       (theme),
    .pending     (pending),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles while locked is high, bounded at 50.
  task automatic wait_unlock(output int n);
    n = 0;
    while (locked === 1'b1 && n < 50) begin
      n++;
      tick();
    end
  endtask

  // Accept one change and commit it on a later vsync; returns with lockout running.
  task automatic do_commit();
    mode = 1'b1;
    btn_chg = 1'b1; tick();
    btn_chg = 1'b0; tick();
    vsync_start = 1'b1; tick();
    vsync_start = 1'b0;
  endtask

  task automatic test_reset();
    btn_chg = 1'b1;
    mode = 1'b1;
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({vga_player, vga_note, vga_menu} !== 24'hE003FF) begin
      failures++;
      $display("FAIL reset_colours got=%h want=E003FF", {vga_player, vga_note, vga_menu});
    end
    checks++;
    if ({theme, pending, locked} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state got theme=%0d pend=%b lock=%b want 0/0/0", theme, pending, locked);
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (pending !== 1'b0 || theme !== 2'd0) begin
        failures++;
        $display("FAIL held_btn_no_fire cyc=%0d pend=%b theme=%0d want 0/0", i, pending, theme);
      end
    end
    btn_chg = 1'b0;
    tick();
  endtask

  task automatic test_basic_commit();
    int n;
    mode = 1'b1;
    btn_chg = 1'b1; tick();
    btn_chg = 1'b0;
    checks++;
    if (pending !== 1'b1) begin
      failures++;
      $display("FAIL basic_pending got=%b want=1", pending);
    end
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (pending !== 1'b1 || theme !== 2'd0) begin
      failures++;
      $display("FAIL basic_waits got pend=%b theme=%0d want 1/0", pending, theme);
    end
    vsync_start = 1'b1; tick();
    vsync_start = 1'b0;
    checks++;
    if (theme !== 2'd1 || {vga_player, vga_note, vga_menu} !== 24'h557AAA) begin
      failures++;
      $display("FAIL basic_commit got theme=%0d col=%h want 1/557AAA", theme,
               {vga_player, vga_note, vga_menu});
    end
    checks++;
    if (pending !== 1'b0 || locked !== 1'b1) begin
      failures++;
      $display("FAIL basic_locked got pend=%b lock=%b want 0/1", pending, locked);
    end
    wait_unlock(n);
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL basic_lock_len got=%0d want=8", n);
    end
    // an edge on the first IDLE cycle after lockout is accepted
    btn_chg = 1'b1; tick();
    btn_chg = 1'b0;
    checks++;
    if (pending !== 1'b1) begin
      failures++;
      $display("FAIL post_lock_accept got=%b want=1", pending);
    end
    mode = 1'b0; tick();
  endtask

  task automatic test_wrap_drop();
    logic [1:0] exp_seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    int n;
    rst = 1'b0; btn_chg = 1'b0; tick();
    rst = 1'b1; mode = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      btn_chg = 1'b1; tick();
      btn_chg = 1'b0; tick();
      btn_chg = 1'b1; tick();
      btn_chg = 1'b0; tick();
      vsync_start = 1'b1; tick();
      vsync_start = 1'b0;
      checks++;
      if (theme !== exp_seq[i] || vga_player !== exp_pl[exp_seq[i]] ||
          vga_note !== exp_nt[exp_seq[i]] || vga_menu !== exp_mn[exp_seq[i]]) begin
        failures++;
        $display("FAIL wrap_step%0d got theme=%0d col=%h%h%h want theme=%0d", i, theme,
                 vga_player, vga_note, vga_menu, exp_seq[i]);
      end
      btn_chg = 1'b1; tick();
      btn_chg = 1'b0; tick();
      wait_unlock(n);
      checks++;
      if (n != 6 || pending !== 1'b0) begin
        failures++;
        $display("FAIL wrap_lock%0d got n=%0d pend=%b want 6/0", i, n, pending);
      end
    end
    checks++;
    if ({vga_player, vga_note, vga_menu} !== 24'hE003FF) begin
      failures++;
      $display("FAIL wrap_final got=%h want=E003FF", {vga_player, vga_note, vga_menu});
    end
  endtask

  task automatic test_gating();
    mode = 1'b0;
    btn_chg = 1'b1; tick();
    btn_chg = 1'b0;
    checks++;
    if (pending !== 1'b0) begin
      failures++;
      $display("FAIL gameplay_edge got pend=%b want=0", pending);
    end
    tick();
    mode = 1'b1;
    btn_chg = 1'b1; tick();
    btn_chg = 1'b0;
    checks++;
    if (pending !== 1'b1) begin
      failures++;
      $display("FAIL cancel_accept got pend=%b want=1", pending);
    end
    mode = 1'b0; tick();
    checks++;
    if (pending !== 1'b0 || theme !== 2'd0 || {vga_player, vga_note, vga_menu} !== 24'hE003FF) begin
      failures++;
      $display("FAIL cancel got pend=%b theme=%0d col=%h want 0/0/E003FF", pending, theme,
               {vga_player, vga_note, vga_menu});
    end
    mode = 1'b1;
    vsync_start = 1'b1; tick();
    vsync_start = 1'b0;
    checks++;
    if (theme !== 2'd0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL vsync_idle got theme=%0d lock=%b want 0/0", theme, locked);
    end
  endtask

  task automatic test_same_cycle();
    int n;
    mode = 1'b1;
    btn_chg = 1'b1; vsync_start = 1'b1; tick();
    btn_chg = 1'b0; vsync_start = 1'b0;
    checks++;
    if (pending !== 1'b1 || theme !== 2'd0) begin
      failures++;
      $display("FAIL same_cycle_wait got pend=%b theme=%0d want 1/0", pending, theme);
    end
    tick(); tick();
    vsync_start = 1'b1; tick();
    vsync_start = 1'b0;
    checks++;
    if (theme !== 2'd1 || locked !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle_commit got theme=%0d lock=%b want 1/1", theme, locked);
    end
    wait_unlock(n);
  endtask

  task automatic test_reset_mid();
    int n;
    mode = 1'b1;
    btn_chg = 1'b1; tick();
    btn_chg = 1'b0;
    rst = 1'b0; tick();
    checks++;
    if (theme !== 2'd0 || {vga_player, vga_note, vga_menu} !== 24'hE003FF ||
        pending !== 1'b0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL reset_pending got theme=%0d col=%h pend=%b lock=%b", theme,
               {vga_player, vga_note, vga_menu}, pending, locked);
    end
    rst = 1'b1; tick();
    do_commit();
    wait_unlock(n);
    do_commit();
    checks++;
    if (theme !== 2'd2 || locked !== 1'b1) begin
      failures++;
      $display("FAIL reach_theme2 got theme=%0d lock=%b want 2/1", theme, locked);
    end
    tick(); tick();
    rst = 1'b0; tick();
    checks++;
    if (theme !== 2'd0 || {vga_player, vga_note, vga_menu} !== 24'hE003FF ||
        pending !== 1'b0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL reset_lockout got theme=%0d col=%h pend=%b lock=%b", theme,
               {vga_player, vga_note, vga_menu}, pending, locked);
    end
    rst = 1'b1; tick();
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_wrap_drop();
    test_gating();
    test_same_cycle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
